serial_pattern_tx: RTL and testbench

//  Serial bit-stream transmitter: accepts WIDTH-bit words on a valid/ready port, shifts them out MSB-first on
//  a 1-bit line with a qualifying strobe. Transmit side for the team's serial 1010 sequence detectors; drives

---
 rtl/serial_tx_pkg.sv | 20 ++
 rtl/serial_pattern_tx_piso.sv | 38 +++
 rtl/serial_pattern_tx.sv | 165 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and constants for the serial pattern transmitter.
//   tx_state_t : FSM state encoding (IDLE, PRE, SHIFT, GAP)
//   PREAMBLE   : word-start sync pattern, sent MSB first (1,0,1,0)
//   PRE_LEN    : number of preamble bits
// ---------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam logic [3:0] PREAMBLE = 4'b1010;
  localparam int         PRE_LEN  = 4;

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// ---------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in / serial-out register. Load has priority over shift; the
// register shifts left so the MSB leaves first.
// Ports:
//   clk      in   clock (posedge)
//   rst      in   synchronous active-high reset, clears the register
//   i_load   in   load i_data this edge
//   i_shift  in   shift left by one this edge (zero fill)
//   i_data   in   WIDTH-bit parallel load value
//   o_msb    out  current MSB of the register
// ---------------------------------------------------------------------------
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
// Serial bit-stream transmitter. Accepts WIDTH-bit words on a valid/ready
// port and shifts them out MSB first on out_bit, qualified by out_valid.
// Optional 1010 preamble before every word when SERIAL_TX_PREAMBLE_EN is
// defined at build time; without it, accepted words go straight to SHIFT.
//
// Handshake: a word transfers on the posedge where in_valid & in_ready are
// both 1. in_ready is decoded from registers only, so upstream may hold
// in_valid/in_data indefinitely; nothing is sampled while in_ready=0.
//
// Ports:
//   clk        in   clock (posedge)
//   rst        in   synchronous active-high reset (wins over acceptance)
//   in_data    in   WIDTH-bit word to send
//   in_valid   in   in_data valid
//   in_ready   out  block can accept this cycle
//   out_bit    out  serial data (0 whenever out_valid=0)
//   out_valid  out  out_bit carries a preamble or data bit
//   busy       out  FSM not in IDLE
//   done       out  pulse during the final data bit of a word
// Parameters:
//   WIDTH       data width (>= 2)
//   GAP_CYCLES  idle bit-times after each word; 0 = back-to-back streaming
// ---------------------------------------------------------------------------
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // A zero-gap build still needs a legal 1-bit counter; it is never used.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

`ifdef SERIAL_TX_PREAMBLE_EN
  localparam tx_state_t START_STATE = PRE;
  localparam logic [1:0] PRE_LAST   = 2'(PRE_LEN - 1);
`else
  localparam tx_state_t START_STATE = SHIFT;
`endif

  tx_state_t       r_state;
  logic [BW-1:0]   r_bit_cnt;
  logic [GW-1:0]   r_gap_cnt;
`ifdef SERIAL_TX_PREAMBLE_EN
  logic [1:0]      r_pre_cnt;
`endif

  logic w_last_bit;
  logic w_in_ready;
  logic w_accept;
  logic w_shift;
  logic w_msb;
  logic w_pre_active;
  logic w_pre_bit;

  assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST);

  // With no gap the next word may be taken during the last data bit so the
  // line never idles between words.
  assign w_in_ready = (r_state == IDLE) || ((GAP_CYCLES == 0) && w_last_bit);
  assign w_accept   = in_valid && w_in_ready;

  // A reload on the last bit overrides the (now pointless) shift.
  assign w_shift = (r_state == SHIFT) && !w_accept;

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_data),
    .o_msb   (w_msb)
  );

`ifdef SERIAL_TX_PREAMBLE_EN
  assign w_pre_active = (r_state == PRE);
  assign w_pre_bit    = PREAMBLE[2'd3 - r_pre_cnt];
`else
  assign w_pre_active = 1'b0;
  assign w_pre_bit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
`ifdef SERIAL_TX_PREAMBLE_EN
      r_pre_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= START_STATE;
            r_bit_cnt <= '0;
          end
        end
`ifdef SERIAL_TX_PREAMBLE_EN
        PRE: begin
          if (r_pre_cnt == PRE_LAST) begin
            r_state   <= SHIFT;
            r_pre_cnt <= '0;
          end else begin
            r_pre_cnt <= r_pre_cnt + 2'd1;
          end
        end
`endif
        SHIFT: begin
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            if (w_accept) begin
              r_state <= START_STATE;
            end else if (GAP_CYCLES > 0) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: functions of registered state only.
  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == SHIFT) || w_pre_active;
  assign out_bit   = (r_state == SHIFT) ? w_msb :
                     w_pre_active       ? w_pre_bit : 1'b0;
  assign busy      = (r_state != IDLE);
  assign done      = w_last_bit;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_tx
// Two transmitters share one clock: dut1 with a one-cycle gap, dut0 with
// back-to-back streaming. Every accepted word pushes its expected line bits
// ({done,bit}, preamble first when enabled) into a per-DUT queue; a negedge
// monitor pops and compares each valid bit and checks the idle line.
// ---------------------------------------------------------------------------
module tb_serial_pattern_tx;

  localparam int W = 8;
`ifdef SERIAL_TX_PREAMBLE_EN
  localparam int PRE_N = 4;
`else
  localparam int PRE_N = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1, rst0;
  logic [W-1:0] in_data1, in_data0;
  logic         in_valid1, in_valid0;
  logic         in_ready1, in_ready0;
  logic         out_bit1, out_bit0;
  logic         out_valid1, out_valid0;
  logic         busy1, busy0;
  logic         done1, done0;

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_bit(out_bit1), .out_valid(out_valid1),
    .busy(busy1), .done(done1)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_bit(out_bit0), .out_valid(out_valid0),
    .busy(busy0), .done(done0)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q1[$];
  logic [1:0] exp_q0[$];

  bit   mon_en = 1'b0;
  bit   det_en = 1'b0;
  logic [3:0] det_hist = 4'b0;
  int   det_cnt  = 0;
  int   det_hits = 0;
  int   det_pos  = 0;
  int   run0     = 0;
  int   max_run0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int sel, input logic [W-1:0] d);
    logic [3:0] pre;
    logic [1:0] e;
    pre = 4'b1010;
    for (int i = 0; i < PRE_N; i++) begin
      e = {1'b0, pre[3-i]};
      if (sel == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    for (int i = W - 1; i >= 0; i--) begin
      e = {(i == 0), d[i]};
      if (sel == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (out_valid1 === 1'b1) begin
        chk("dut1_q_avail", 32'(exp_q1.size() != 0), 1);
        if (exp_q1.size() != 0) begin
          e = exp_q1.pop_front();
          chk("dut1_done_bit", {30'b0, done1, out_bit1}, {30'b0, e});
        end
        if (det_en) begin
          det_hist = {det_hist[2:0], out_bit1};
          det_cnt++;
          if (det_cnt >= 4 && det_hist == 4'b1010) begin
            det_hits++;
            det_pos = det_cnt;
          end
        end
      end else begin
        chk("dut1_idle_line", {29'b0, out_valid1, done1, out_bit1}, 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (out_valid0 === 1'b1) begin
        run0++;
        if (run0 > max_run0) max_run0 = run0;
        chk("dut0_q_avail", 32'(exp_q0.size() != 0), 1);
        if (exp_q0.size() != 0) begin
          e = exp_q0.pop_front();
          chk("dut0_done_bit", {30'b0, done0, out_bit0}, {30'b0, e});
        end
      end else begin
        run0 = 0;
        chk("dut0_idle_line", {29'b0, out_valid0, done0, out_bit0}, 0);
      end
    end
  end

  // driver tasks
  task automatic send(input int sel, input logic [W-1:0] d, input bit release_valid);
    int  n;
    logic rdy;
    if (sel == 0) begin in_valid0 = 1'b1; in_data0 = d; end
    else          begin in_valid1 = 1'b1; in_data1 = d; end
    n = 0;
    forever begin
      @(negedge clk);
      rdy = (sel == 0) ? in_ready0 : in_ready1;
      if (rdy === 1'b1) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(rdy), 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    push_word(sel, d);
    if (release_valid) begin
      if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int sel);
    int   n;
    logic b;
    n = 0;
    forever begin
      @(negedge clk);
      b = (sel == 0) ? busy0 : busy1;
      if (b === 1'b0) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 32'(b), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // directed sequence
  initial begin
    rst1 = 1'b1; rst0 = 1'b1;
    in_valid1 = 1'b0; in_valid0 = 1'b0;
    in_data1 = '0; in_data0 = '0;

    // 1. reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready1",  32'(in_ready1),  1);
    chk("rst_out_valid1", 32'(out_valid1), 0);
    chk("rst_out_bit1",   32'(out_bit1),   0);
    chk("rst_busy1",      32'(busy1),      0);
    chk("rst_done1",      32'(done1),      0);
    chk("rst_in_ready0",  32'(in_ready0),  1);
    chk("rst_out_valid0", 32'(out_valid0), 0);
    chk("rst_busy0",      32'(busy0),      0);
    rst1 = 1'b0; rst0 = 1'b0;
    mon_en = 1'b1;

    // 2. single word A5 with gap; cycle k+1 after accept edge k
    in_valid1 = 1'b1; in_data1 = 8'hA5;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    push_word(1, 8'hA5);
    chk("a5_busy_k1",  32'(busy1),     1);
    chk("a5_ready_k1", 32'(in_ready1), 0);
    repeat (PRE_N + 7) @(posedge clk);
    #1;
    chk("a5_done_last", 32'(done1), 1);
    @(posedge clk); #1;
    chk("a5_gap_valid", 32'(out_valid1), 0);
    chk("a5_gap_busy",  32'(busy1),      1);
    chk("a5_gap_ready", 32'(in_ready1),  0);
    @(posedge clk); #1;
    chk("a5_ready_after_gap", 32'(in_ready1), 1);
    chk("a5_busy_after_gap",  32'(busy1),     0);
    chk("a5_q_drained", 32'(exp_q1.size()), 0);

    // 3. back-to-back F0 then 0F on the zero-gap instance
    send(0, 8'hF0, 1'b0);
    send(0, 8'h0F, 1'b1);
    wait_idle(0);
    chk("b2b_contiguous_run", 32'(max_run0), 32'(2 * (W + PRE_N)));
    chk("b2b_q_drained", 32'(exp_q0.size()), 0);

    // 4. word offered while busy is held off until in_ready rises
    send(1, 8'h3C, 1'b1);
    in_valid1 = 1'b1; in_data1 = 8'hFF;
    chk("held_ready_low", 32'(in_ready1), 0);
    send(1, 8'hFF, 1'b1);
    wait_idle(1);
    chk("held_q_drained", 32'(exp_q1.size()), 0);

    // 5. reset in bit cycle 3 aborts the word
    send(1, 8'hFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    exp_q1.delete();
    chk("abort_out_valid", 32'(out_valid1), 0);
    chk("abort_in_ready",  32'(in_ready1),  1);
    chk("abort_done",      32'(done1),      0);
    chk("abort_busy",      32'(busy1),      0);
    send(1, 8'h81, 1'b1);
    wait_idle(1);
    chk("after_abort_q_drained", 32'(exp_q1.size()), 0);

    // 6. all-zero word through a 1010 detector on the line
    det_hist = 4'b0; det_cnt = 0; det_hits = 0; det_pos = 0;
    det_en = 1'b1;
    send(1, 8'h00, 1'b1);
    wait_idle(1);
    det_en = 1'b0;
    chk("zero_word_valid_cycles", 32'(det_cnt), 32'(W + PRE_N));
    chk("det_hits", 32'(det_hits), (PRE_N > 0) ? 32'd1 : 32'd0);
    chk("det_pos",  32'(det_pos),  (PRE_N > 0) ? 32'd4 : 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("final_q1_empty", 32'(exp_q1.size()), 0);
    chk("final_q0_empty", 32'(exp_q0.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
